df_tap_sequencer: RTL and testbench

//  Time-multiplexed FIR tap controller for the shared 8x3 coefficient multiplier (df_multiplier_c2).
//  - Accepts 8-bit samples over a valid/ready handshake and keeps a TAPS-deep delay line.
//  - Steps one tap per cycle through the external multiplier and accumulates the products.
//  - Presents the filter sum on a valid/ready output; per-tap 3-bit coefficients are loaded through a config port.

---
 rtl/df_tap_sequencer.sv | 118 +++++++++++
 tb/tb_df_tap_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/df_tap_sequencer.sv
// Time-multiplexed FIR tap controller driving one shared coefficient multiplier, one tap per cycle.
// Latency: result valid TAPS cycles after the accepting edge; in_ready only in IDLE, result held until out_ready.
// Optional DF_TAP_SEQ_SAT_EN clamps out_data to 255; otherwise the full ACC_W-bit sum is presented.
module df_tap_sequencer #(
    parameter int TAPS  = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [2:0]       cfg_coef,
    output logic             cfg_ready,
    output logic [2:0]       mul_coef,
    output logic [7:0]       mul_data,
    input  logic [7:0]       mul_out
);

    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t           state;
    logic [7:0]       taps  [TAPS];
    logic [2:0]       coefs [TAPS];
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] result;
    logic [IW-1:0]    idx;
    logic             cfg_hit;

    assign acc_sum = acc + ACC_W'(mul_out);

`ifdef DF_TAP_SEQ_SAT_EN
    assign result = (acc_sum > ACC_W'(255)) ? ACC_W'(255) : acc_sum;
`else
    assign result = acc_sum;
`endif

    // Out-of-range addresses must not alias onto a real tap through the truncated index.
    assign cfg_hit = cfg_we && cfg_ready && ({1'b0, cfg_addr} < 5'(TAPS));

    always_comb begin
        mul_coef = '0;
        mul_data = '0;
        if (state == MAC) begin
            mul_coef = coefs[idx];
            mul_data = taps[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cfg_ready <= 1'b1;
            out_data  <= '0;
            acc       <= '0;
            idx       <= '0;
            for (int k = 0; k < TAPS; k++) begin
                taps[k]  <= '0;
                coefs[k] <= '0;
            end
        end else begin
            if (cfg_hit) begin
                coefs[cfg_addr[IW-1:0]] <= cfg_coef;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        taps[0] <= in_data;
                        for (int k = 1; k < TAPS; k++) begin
                            taps[k] <= taps[k-1];
                        end
                        acc       <= '0;
                        idx       <= '0;
                        state     <= MAC;
                        in_ready  <= 1'b0;
                        cfg_ready <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (idx == IW'(TAPS - 1)) begin
                        idx       <= '0;
                        state     <= DONE;
                        out_data  <= result;
                        out_valid <= 1'b1;
                        cfg_ready <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_df_tap_sequencer.sv
// Bench for df_tap_sequencer: stand-in coefficient multiplier, queue scoreboard, directed and random phases.
module tb_df_tap_sequencer;

    localparam int TAPS  = 4;
    localparam int ACC_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_addr = '0;
    logic [2:0]       cfg_coef = '0;
    logic             cfg_ready;
    logic [2:0]       mul_coef;
    logic [7:0]       mul_data;
    logic [7:0]       mul_out;

    int checks = 0;
    int errors = 0;
    int q[$];
    int last_out = 0;
    int result_cnt = 0;

    int m_tap  [TAPS];
    int m_coef [TAPS];
    int m_phase = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    // Coefficient code to gain; product = data*gain >> 7 stays within 0..127.
    function automatic int coef_gain(input logic [2:0] c);
        case (c)
            3'd0: return 5;
            3'd1: return 7;
            3'd2: return 10;
            3'd3: return 15;
            3'd4: return 21;
            3'd5: return 28;
            3'd6: return 37;
            default: return 47;
        endcase
    endfunction

    function automatic logic [7:0] mul_model(input logic [2:0] c, input logic [7:0] d);
        int p;
        p = int'(d) * coef_gain(c);
        return 8'(p >> 7);
    endfunction

    assign mul_out = mul_model(mul_coef, mul_data);

    df_tap_sequencer #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coef(cfg_coef), .cfg_ready(cfg_ready),
        .mul_coef(mul_coef), .mul_data(mul_data), .mul_out(mul_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic int model_sum();
        int s;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += (m_tap[k] * coef_gain(3'(m_coef[k]))) >> 7;
`ifdef DF_TAP_SEQ_SAT_EN
        if (s > 255) s = 255;
`endif
        return s;
    endfunction

    // Reference model: protocol expectations per cycle plus expected sums pushed on acceptance.
    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_cnt = 0;
            for (int k = 0; k < TAPS; k++) begin
                m_tap[k] = 0;
                m_coef[k] = 0;
            end
            q.delete();
        end else begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("cfg_ready", cfg_ready, m_phase != 1);
            chk("out_valid", out_valid, m_phase == 2);
            if (m_phase != 1) begin
                chk("mul_coef_idle", mul_coef, 0);
                chk("mul_data_idle", mul_data, 0);
            end
            if (cfg_we && m_phase != 1 && cfg_addr < TAPS) m_coef[cfg_addr] = cfg_coef;
            case (m_phase)
                0: if (in_valid) begin
                    for (int k = TAPS - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
                    m_tap[0] = in_data;
                    q.push_back(model_sum());
                    m_phase = 1;
                    m_cnt = TAPS;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Monitor: every presented result must match the head of the scoreboard while it is held.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0d expected none", out_data);
            end else begin
                chk("out_data", out_data, q[0]);
                if (out_ready) begin
                    last_out = out_data;
                    void'(q.pop_front());
                    result_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] s);
        bit got;
        int guard;
        in_valid = 1'b1;
        in_data = s;
        got = 0;
        guard = 0;
        while (!got && guard < 100) begin
            @(negedge clk);
            got = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!got) fail_now("push");
    endtask

    task automatic wait_next(input string name, input int base, input int expv);
        int g;
        g = 0;
        while (result_cnt == base && g < 100) begin
            tick();
            g++;
        end
        if (result_cnt == base) fail_now(name);
        else if (expv >= 0) chk(name, last_out, expv);
    endtask

    task automatic run_one(input string name, input logic [7:0] s, input int expv);
        int base;
        base = result_cnt;
        push(s);
        wait_next(name, base, expv);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [2:0] c);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_coef = c;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int g;

        // Reset in the middle of MAC aborts the sample.
        do_reset(2);
        base = result_cnt;
        push(8'd200);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        repeat (12) tick();
        chk("rst_no_result", result_cnt, base);

        // Impulse through all-7 coefficients.
        for (int a = 0; a < TAPS; a++) cfg_write(4'(a), 3'd7);
        run_one("impulse0", 8'd200, 73);
        run_one("impulse1", 8'd0, 73);
        run_one("impulse2", 8'd0, 73);
        run_one("impulse3", 8'd0, 73);
        run_one("impulse4", 8'd0, 0);

        // Default coefficients after reset.
        do_reset(2);
        run_one("default", 8'd200, 7);
        cfg_write(4'd1, 3'd2);
        run_one("coef1", 8'd100, 18);

        // Backpressure: result held, inputs ignored, then a sample offered on the release edge.
        out_ready = 1'b0;
        base = result_cnt;
        push(8'd50);
        g = 0;
        do begin
            tick();
            @(negedge clk);
            g++;
        end while (!out_valid && g < 50);
        if (!out_valid) fail_now("bp_valid");
        repeat (10) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            tick();
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_held", result_cnt, base);
            chk("bp_data", out_data, 15);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        push(8'd77);
        chk("bp_release", result_cnt, base + 1);
        chk("bp_result", last_out, 15);
        wait_next("bp_follow", base + 1, 16);

        // Config writes during MAC are dropped; in IDLE they apply to the next sample.
        base = result_cnt;
        push(8'd120);
        cfg_write(4'd0, 3'd3);
        wait_next("guard_mac", base, 14);
        cfg_write(4'd0, 3'd3);
        run_one("guard_idle", 8'd120, 27);
        cfg_write(4'd5, 3'd7);
        run_one("guard_range", 8'd0, 16);

        // Large sums: saturation build clamps at 255.
        do_reset(2);
        for (int a = 0; a < TAPS; a++) cfg_write(4'(a), 3'd7);
        run_one("sat1", 8'd255, 93);
        run_one("sat2", 8'd255, 186);
`ifdef DF_TAP_SEQ_SAT_EN
        run_one("sat3", 8'd255, 255);
        run_one("sat4", 8'd255, 255);
`else
        run_one("sat3", 8'd255, 279);
        run_one("sat4", 8'd255, 372);
`endif

        // Random traffic against the model.
        do_reset(2);
        repeat (500) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_addr = 4'($urandom_range(0, 7));
            cfg_coef = 3'($urandom);
            tick();
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        chk("drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
